// File: rtl/predistort_taps_loader_if.sv
// Settings-bus write port, tap stream and status signals of the predistortion tap loader.
// The host drives the settings bus and taps_tready; the loader drives the rest.
interface predistort_taps_loader_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 7
);
    logic             set_stb;
    logic [7:0]       set_addr;
    logic [31:0]      set_data;
    logic [WIDTH-1:0] taps_tdata;
    logic             taps_tlast;
    logic             taps_tvalid;
    logic             taps_tready;
    logic             busy;
    logic [DEPTH-1:0] wr_ptr;
    logic             dropped;

    modport master (
        output set_stb, set_addr, set_data, taps_tready,
        input  taps_tdata, taps_tlast, taps_tvalid, busy, wr_ptr, dropped
    );

    modport slave (
        input  set_stb, set_addr, set_data, taps_tready,
        output taps_tdata, taps_tlast, taps_tvalid, busy, wr_ptr, dropped
    );
endinterface

// File: rtl/predistort_taps_loader.sv
// Loads a 2^DEPTH tap table over the settings bus and streams it out on commit
// as an AXI-stream burst with no bubbles under continuous ready.
module predistort_taps_loader #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 7,
    parameter int SR_BASE = 0
) (
    input logic clk,
    input logic reset,
    input logic clear,
    predistort_taps_loader_if.slave bus
);
    localparam int         N         = 1 << DEPTH;
    localparam logic [7:0] ADDR_TAP  = 8'(SR_BASE);
    localparam logic [7:0] ADDR_CTRL = 8'(SR_BASE + 1);

    typedef enum logic [1:0] {IDLE, PREFETCH, STREAM} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] mem [N];
    logic [WIDTH-1:0] rd_data;
    logic [DEPTH-1:0] rd_addr;
    logic [DEPTH-1:0] rd_idx;
    logic [DEPTH-1:0] wr_ptr_q;
    logic             fetch_valid;
    logic             fetch_last;

    logic [WIDTH-1:0] tdata_q;
    logic             tlast_q;
    logic             tvalid_q;
    logic             busy_q;
    logic             dropped_q;

    logic sync_clr;
    logic tap_stb;
    logic ctrl_stb;
    logic commit_req;
    logic last_xfer;
    logic wr_en;
    logic rd_en;
    logic out_adv;
    logic drop_evt;

    assign sync_clr   = reset | clear;
    assign tap_stb    = bus.set_stb && (bus.set_addr == ADDR_TAP);
    assign ctrl_stb   = bus.set_stb && (bus.set_addr == ADDR_CTRL);
    assign commit_req = ctrl_stb && bus.set_data[0];
    assign last_xfer  = tvalid_q && bus.taps_tready && tlast_q;

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (commit_req) state_next = PREFETCH;
            PREFETCH: state_next = STREAM;
            STREAM:   if (last_xfer) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Fetch register (rd_data) and output register form a two-stage pipeline that
    // advances as a whole whenever the output stage is empty or being accepted.
    always_comb begin
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = rd_idx;
        out_adv  = 1'b0;
        drop_evt = 1'b0;
        case (state)
            IDLE: begin
                wr_en = tap_stb && !sync_clr;
            end
            PREFETCH: begin
                rd_en    = 1'b1;
                rd_addr  = '0;
                drop_evt = tap_stb || commit_req;
            end
            STREAM: begin
                out_adv  = !tvalid_q || bus.taps_tready;
                rd_en    = out_adv && fetch_valid && !fetch_last;
                drop_evt = tap_stb || commit_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.set_data[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            dropped_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_idx      <= '0;
            fetch_valid <= 1'b0;
            fetch_last  <= 1'b0;
        end else begin
            busy_q <= (state_next != IDLE);

            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + DEPTH'(1);
            end else if (ctrl_stb && bus.set_data[1]) begin
                wr_ptr_q <= '0;
            end

            if (ctrl_stb && bus.set_data[2]) begin
                dropped_q <= 1'b0;
            end
            if (drop_evt) begin
                dropped_q <= 1'b1;
            end

            if (rd_en) begin
                rd_idx      <= rd_addr + DEPTH'(1);
                fetch_last  <= (rd_addr == '1);
                fetch_valid <= 1'b1;
            end else if (out_adv) begin
                fetch_valid <= 1'b0;
            end

            if (out_adv) begin
                tvalid_q <= fetch_valid;
                tlast_q  <= fetch_valid && fetch_last;
                if (fetch_valid) begin
                    tdata_q <= rd_data;
                end
            end
        end
    end

    generate
        if (WIDTH < 32) begin : g_spare_bits
            logic unused_set_data;
            assign unused_set_data = ^bus.set_data[31:WIDTH];
        end
    endgenerate

    assign bus.taps_tdata  = tdata_q;
    assign bus.taps_tlast  = tlast_q;
    assign bus.taps_tvalid = tvalid_q;
    assign bus.busy        = busy_q;
    assign bus.wr_ptr      = wr_ptr_q;
    assign bus.dropped     = dropped_q;
endmodule

// File: tb/tb_predistort_taps_loader.sv
// Directed bench for predistort_taps_loader: a per-cycle vector table for the settings
// bus and control bits, then hand-written full-stream sequences for the burst corners.
module tb_predistort_taps_loader;
    localparam int N = 128;

    logic clk;
    logic reset;
    logic clear;

    predistort_taps_loader_if #(.WIDTH(16), .DEPTH(7)) bus ();

    predistort_taps_loader #(.WIDTH(16), .DEPTH(7), .SR_BASE(0)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] expv [N];

    typedef struct {
        logic        stb;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [6:0]  e_wp;
        logic        e_busy;
        logic        e_drop;
        logic        e_tvalid;
        logic        chk_data;
        logic [15:0] e_data;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_tap(input logic [15:0] d);
        bus.set_stb  = 1'b1;
        bus.set_addr = 8'h00;
        bus.set_data = 32'hA5A5_0000 | 32'(d);
        @(negedge clk);
        bus.set_stb  = 1'b0;
    endtask

    task automatic ctrl_write(input logic [31:0] d);
        bus.set_stb  = 1'b1;
        bus.set_addr = 8'h01;
        bus.set_data = d;
        @(negedge clk);
        bus.set_stb  = 1'b0;
    endtask

    // Commit, check the two-cycle latency, then consume the burst against expv.
    task automatic run_stream(input logic [31:0] commit_word, input bit rnd,
                              input int inject_at, input int abort_at);
        int idx = 0;
        int cyc = 0;
        int first_beat = -1;
        int last_beat = -1;
        bit stalled = 1'b0;
        logic [15:0] hold_d = '0;
        logic hold_l = 1'b0;
        bus.taps_tready = 1'b1;
        bus.set_stb  = 1'b1;
        bus.set_addr = 8'h01;
        bus.set_data = commit_word;
        @(negedge clk);
        bus.set_stb = 1'b0;
        check("commit_busy", 32'(bus.busy), 32'd1);
        check("lat_k0_tvalid", 32'(bus.taps_tvalid), 32'd0);
        @(negedge clk);
        check("lat_k1_tvalid", 32'(bus.taps_tvalid), 32'd0);
        @(negedge clk);
        check("lat_k2_tvalid", 32'(bus.taps_tvalid), 32'd1);
        check("lat_k2_data", 32'(bus.taps_tdata), 32'(expv[0]));
        while (idx < N && cyc < 4000) begin
            if (stalled) begin
                check("stall_tvalid", 32'(bus.taps_tvalid), 32'd1);
                check("stall_tdata", 32'(bus.taps_tdata), 32'(hold_d));
                check("stall_tlast", 32'(bus.taps_tlast), 32'(hold_l));
            end
            if (cyc == abort_at) begin
                reset = 1'b1;
                bus.set_stb = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                check("abort_tvalid", 32'(bus.taps_tvalid), 32'd0);
                check("abort_tlast", 32'(bus.taps_tlast), 32'd0);
                check("abort_busy", 32'(bus.busy), 32'd0);
                check("abort_wr_ptr", 32'(bus.wr_ptr), 32'd0);
                check("abort_beats", 32'(idx), 32'(abort_at));
                return;
            end
            bus.set_stb = 1'b0;
            if (cyc == inject_at) begin
                bus.set_stb  = 1'b1;
                bus.set_addr = 8'h00;
                bus.set_data = 32'h0000_BEEF;
            end else if (cyc == inject_at + 1) begin
                bus.set_stb  = 1'b1;
                bus.set_addr = 8'h01;
                bus.set_data = 32'h1;
            end
            bus.taps_tready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            stalled = 1'b0;
            if (bus.taps_tvalid && bus.taps_tready) begin
                check($sformatf("beat%0d_data", idx), 32'(bus.taps_tdata), 32'(expv[idx]));
                check($sformatf("beat%0d_last", idx), 32'(bus.taps_tlast), 32'(idx == N - 1));
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                idx++;
            end else if (bus.taps_tvalid) begin
                stalled = 1'b1;
                hold_d  = bus.taps_tdata;
                hold_l  = bus.taps_tlast;
            end
            @(negedge clk);
            cyc++;
        end
        bus.set_stb = 1'b0;
        check("stream_beats", 32'(idx), 32'(N));
        if (!rnd) check("no_bubbles", 32'(last_beat - first_beat), 32'(N - 1));
        repeat (2) @(negedge clk);
        check("end_tvalid", 32'(bus.taps_tvalid), 32'd0);
        check("end_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        bus.set_stb = 1'b0;
        bus.set_addr = '0;
        bus.set_data = '0;
        bus.taps_tready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tvalid", 32'(bus.taps_tvalid), 32'd0);
        check("rst_tlast", 32'(bus.taps_tlast), 32'd0);
        check("rst_tdata", 32'(bus.taps_tdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wr_ptr", 32'(bus.wr_ptr), 32'd0);
        check("rst_dropped", 32'(bus.dropped), 32'd0);
        reset = 1'b0;

        //          stb  addr   data            wp    busy drop tv   chk  data
        vecs[0]  = '{1'b0, 8'h00, 32'h0,        7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[1]  = '{1'b1, 8'h00, 32'h0000AAAA, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[2]  = '{1'b1, 8'h05, 32'h00001234, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[3]  = '{1'b1, 8'h00, 32'h00005555, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[4]  = '{1'b1, 8'h01, 32'h2,        7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[5]  = '{1'b1, 8'h00, 32'h00005A5A, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[6]  = '{1'b1, 8'h01, 32'h1,        7'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[7]  = '{1'b0, 8'h00, 32'h0,        7'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
        vecs[8]  = '{1'b0, 8'h00, 32'h0,        7'd1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5A5A};
        vecs[9]  = '{1'b1, 8'h00, 32'h0000BEEF, 7'd1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5A5A};
        vecs[10] = '{1'b1, 8'h01, 32'h4,        7'd1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5A5A};
        vecs[11] = '{1'b1, 8'h01, 32'h1,        7'd1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5A5A};
        vecs[12] = '{1'b1, 8'h01, 32'h2,        7'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5A5A};

        foreach (vecs[i]) begin
            bus.set_stb  = vecs[i].stb;
            bus.set_addr = vecs[i].addr;
            bus.set_data = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d_wr_ptr", i), 32'(bus.wr_ptr), 32'(vecs[i].e_wp));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_dropped", i), 32'(bus.dropped), 32'(vecs[i].e_drop));
            check($sformatf("vec%0d_tvalid", i), 32'(bus.taps_tvalid), 32'(vecs[i].e_tvalid));
            if (vecs[i].chk_data)
                check($sformatf("vec%0d_tdata", i), 32'(bus.taps_tdata), 32'(vecs[i].e_data));
        end
        bus.set_stb = 1'b0;

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_tvalid", 32'(bus.taps_tvalid), 32'd0);
        check("clr_busy", 32'(bus.busy), 32'd0);
        check("clr_wr_ptr", 32'(bus.wr_ptr), 32'd0);
        check("clr_dropped", 32'(bus.dropped), 32'd0);

        // Ramp load, continuous ready, then random ready on the same contents
        for (int i = 0; i < N; i++) begin
            write_tap(16'(i));
            expv[i] = 16'(i);
        end
        check("load_wr_ptr", 32'(bus.wr_ptr), 32'd0);
        run_stream(32'h1, 1'b0, -100, -100);
        run_stream(32'h1, 1'b1, -100, -100);

        // 130 writes wrap the pointer over the first two entries
        for (int i = 0; i < 130; i++) write_tap(16'h1000 + 16'(i));
        check("wrap_wr_ptr", 32'(bus.wr_ptr), 32'd2);
        for (int i = 0; i < N; i++) expv[i] = (i < 2) ? 16'h1080 + 16'(i) : 16'h1000 + 16'(i);
        run_stream(32'h1, 1'b0, -100, -100);
        check("wrap_ptr_kept", 32'(bus.wr_ptr), 32'd2);

        // Tap write and second commit during a stream are dropped
        ctrl_write(32'h2);
        for (int i = 0; i < N; i++) begin
            write_tap(16'h2000 + 16'(i));
            expv[i] = 16'h2000 + 16'(i);
        end
        run_stream(32'h1, 1'b0, 10, -100);
        check("drop_flag", 32'(bus.dropped), 32'd1);
        check("drop_wr_ptr", 32'(bus.wr_ptr), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_second_tvalid", 32'(bus.taps_tvalid), 32'd0);
            check("no_second_busy", 32'(bus.busy), 32'd0);
        end
        ctrl_write(32'h4);
        check("drop_cleared", 32'(bus.dropped), 32'd0);

        // Reset at beat 40, then a fresh commit restreams the retained table
        run_stream(32'h1, 1'b0, -100, 40);
        run_stream(32'h1, 1'b0, -100, -100);

        // Commit together with pointer reset
        write_tap(16'h0001);
        check("pre_commit_wr_ptr", 32'(bus.wr_ptr), 32'd1);
        expv[0] = 16'h0001;
        run_stream(32'h3, 1'b0, -100, -100);
        check("commit_ptr_reset", 32'(bus.wr_ptr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
